// File: rtl/bounce_step_decoder.sv
// bounce_step_decoder: rebuilds the per-sample step and direction from a bouncing 0..2^WIDTH-1 counter stream.
// Optional saturating error counter with synchronous clear, enabled by `define BOUNCE_DEC_ERRCNT_EN.
module bounce_step_decoder #(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 2,
  parameter int TURN_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  sample,
  input  logic              sample_valid,
`ifdef BOUNCE_DEC_ERRCNT_EN
  input  logic              err_clr,
  output logic [7:0]        err_cnt,
`endif
  output logic [STEP_W-1:0] step,
  output logic              dir_up,
  output logic              step_valid,
  output logic              clamp,
  output logic              turn,
  output logic [TURN_W-1:0] turn_cnt,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

  localparam logic [WIDTH-1:0]  MAX_VAL  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]  MAX_STEP = WIDTH'((1 << STEP_W) - 1);
  localparam logic [TURN_W-1:0] TURN_SAT = {TURN_W{1'b1}};

  state_t              state, state_n;
  logic [WIDTH-1:0]    prev, prev_n;
  logic [WIDTH:0]      diff;
  logic                in_range;
  logic [STEP_W-1:0]   step_n;
  logic                dir_up_n, step_valid_n, clamp_n, turn_n, err_n;

  // Distance travelled in the expected direction; the extra MSB flags a move the wrong way.
  always_comb begin
    diff = '0;
    if (state == DOWN) diff = {1'b0, prev} - {1'b0, sample};
    else               diff = {1'b0, sample} - {1'b0, prev};
    in_range = !diff[WIDTH] && (diff[WIDTH-1:0] <= MAX_STEP);
  end

  always_comb begin
    state_n      = state;
    prev_n       = prev;
    step_n       = step;
    dir_up_n     = dir_up;
    clamp_n      = clamp;
    step_valid_n = 1'b0;
    turn_n       = 1'b0;
    err_n        = 1'b0;
    if (sample_valid) begin
      prev_n = sample;
      case (state)
        IDLE: begin
          state_n = UP;
          if (sample != '0) begin
            err_n  = 1'b1;
            step_n = '0;
          end
        end
        UP, DOWN: begin
          if (in_range) begin
            step_n       = diff[STEP_W-1:0];
            dir_up_n     = (state == UP);
            step_valid_n = 1'b1;
            clamp_n      = 1'b0;
            if (state == UP && sample == MAX_VAL) begin
              clamp_n = 1'b1;
              turn_n  = 1'b1;
              state_n = DOWN;
            end else if (state == DOWN && sample == '0) begin
              clamp_n = 1'b1;
              turn_n  = 1'b1;
              state_n = UP;
            end
          end else begin
            // Resync on the offending value; only a boundary value tells us the new direction.
            err_n  = 1'b1;
            step_n = '0;
            if (sample == MAX_VAL)  state_n = DOWN;
            else if (sample == '0) state_n = UP;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      prev       <= '0;
      step       <= '0;
      dir_up     <= 1'b0;
      step_valid <= 1'b0;
      clamp      <= 1'b0;
      turn       <= 1'b0;
      err        <= 1'b0;
      turn_cnt   <= '0;
    end else begin
      state      <= state_n;
      prev       <= prev_n;
      step       <= step_n;
      dir_up     <= dir_up_n;
      step_valid <= step_valid_n;
      clamp      <= clamp_n;
      turn       <= turn_n;
      err        <= err_n;
      if (turn_n && turn_cnt != TURN_SAT) turn_cnt <= turn_cnt + TURN_W'(1);
    end
  end

`ifdef BOUNCE_DEC_ERRCNT_EN
  // A clear in the same cycle as an error wins, so the count restarts from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          err_cnt <= '0;
    else if (err_clr)                  err_cnt <= '0;
    else if (err_n && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule
